// File: rtl/sensor_sample_scheduler_if.sv
// Read handshake between the sample scheduler and the shared sensor read engine.
// The scheduler is the master; the engine answers with ack/data/err.
interface sensor_sample_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              rd_req;
    logic [CH_W-1:0]   rd_ch;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

    modport master (
        output rd_req,
        output rd_ch,
        input  rd_ack,
        input  rd_data,
        input  rd_err
    );

    modport slave (
        input  rd_req,
        input  rd_ch,
        output rd_ack,
        output rd_data,
        output rd_err
    );
endinterface

// File: rtl/sensor_sample_scheduler.sv
// Periodic sensor sampling controller: on each frame tick it reads every
// enabled channel in ascending order and flags completion with an interrupt.
module sensor_sample_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 16,
    parameter int PERIOD_W    = 24,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       cfg_enable,
    input  logic [PERIOD_W-1:0]        cfg_period,
    input  logic [NUM_CH-1:0]          cfg_ch_mask,
    sensor_sample_scheduler_if.master  rd,
    output logic [NUM_CH*DATA_W-1:0]   sample_data,
    output logic [NUM_CH-1:0]          sample_err,
    output logic                       frame_done,
    output logic                       frame_irq,
    output logic                       overrun,
    input  logic                       irq_ack,
    output logic                       busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = CH_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_SCAN      = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]          r_state;
    logic [PERIOD_W-1:0] r_timer;
    logic [NUM_CH-1:0]   r_mask;
    logic [CNT_W-1:0]    r_ch;
    logic [CH_W-1:0]     r_rd_ch;
    logic                r_rd_req;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_abort;
    logic                r_frame_done;
    logic                r_frame_irq;
    logic                r_overrun;
    logic [DATA_W-1:0]   r_sample [NUM_CH];
    logic [NUM_CH-1:0]   r_err;

    logic                w_tick;
    logic                w_found;
    logic [CH_W-1:0]     w_next_ch;
    logic                w_timeout;
    logic                w_busy;
    logic                w_frame_start;

    assign w_tick        = cfg_enable && (r_timer == '0);
    assign w_timeout     = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_busy        = (r_state == S_SCAN) || (r_state == S_ISSUE) ||
                           (r_state == S_WAIT_ACK) || (r_state == S_DONE);
    assign w_frame_start = (r_state == S_WAIT_TICK) && w_tick;

    // Frame period down-counter; reloads on each tick and is held while disabled
    always_ff @(posedge ACLK) begin
        if (ARESET || !cfg_enable) begin
            r_timer <= cfg_period;
        end else if (w_tick) begin
            r_timer <= cfg_period;
        end else begin
            r_timer <= r_timer - 1'b1;
        end
    end

    // Priority encoder: lowest snapshotted channel at or above the scan pointer
    always_comb begin
        w_found   = 1'b0;
        w_next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (CNT_W'(i) >= r_ch)) begin
                w_found   = 1'b1;
                w_next_ch = CH_W'(i);
            end
        end
    end

    // Scan FSM: walks the frame, owns the read request and its timeout
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_ch         <= '0;
            r_rd_ch      <= '0;
            r_rd_req     <= 1'b0;
            r_to_cnt     <= '0;
            r_abort      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cfg_enable) begin
                        r_state <= S_WAIT_TICK;
                    end
                end
                S_WAIT_TICK: begin
                    if (!cfg_enable) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        r_mask  <= cfg_ch_mask;
                        r_ch    <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!cfg_enable) begin
                        r_state <= S_IDLE;
                    end else if (w_found) begin
                        r_rd_ch <= w_next_ch;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (!cfg_enable) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rd_req <= 1'b1;
                        r_to_cnt <= '0;
                        r_abort  <= 1'b0;
                        r_state  <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (!cfg_enable) begin
                        r_abort <= 1'b1;
                    end
                    if (rd.rd_ack || w_timeout) begin
                        r_rd_req <= 1'b0;
                        r_ch     <= {1'b0, r_rd_ch} + 1'b1;
                        r_state  <= (r_abort || !cfg_enable) ? S_IDLE : S_SCAN;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_frame_done <= 1'b1;
                    r_state      <= S_WAIT_TICK;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sample slots and error flags; errors of the new frame's channels clear on its tick
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sample[i] <= '0;
            end
            r_err <= '0;
        end else if (w_frame_start) begin
            r_err <= r_err & ~cfg_ch_mask;
        end else if (r_state == S_WAIT_ACK) begin
            if (rd.rd_ack) begin
                if (rd.rd_err) begin
                    r_err[r_rd_ch] <= 1'b1;
                end else begin
                    r_sample[r_rd_ch] <= rd.rd_data;
                    r_err[r_rd_ch]    <= 1'b0;
                end
            end else if (w_timeout) begin
                r_err[r_rd_ch] <= 1'b1;
            end
        end
    end

    // Sticky interrupt and overrun flags; a set in the same cycle as irq_ack wins
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_frame_irq <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                r_frame_irq <= 1'b1;
            end else if (irq_ack) begin
                r_frame_irq <= 1'b0;
            end
            if (w_tick && w_busy) begin
                r_overrun <= 1'b1;
            end else if (irq_ack) begin
                r_overrun <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign sample_data[g*DATA_W +: DATA_W] = r_sample[g];
    end

    assign rd.rd_req  = r_rd_req;
    assign rd.rd_ch   = r_rd_ch;
    assign sample_err = r_err;
    assign frame_done = r_frame_done;
    assign frame_irq  = r_frame_irq;
    assign overrun    = r_overrun;
    assign busy       = w_busy;

endmodule
